bcd_sample_ctrl: RTL

//  Sequencer between the free-running 16-bit count and the 7-seg decoders.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/dd_step.sv | 31 +++
 rtl/bcd_sample_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sampled binary-to-BCD display path.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DIG_W     = 4;
  localparam int unsigned ADD3_TH   = 5;
  localparam int unsigned DEF_NDIG  = 5;
  localparam int unsigned DEF_WIDTH = 16;

endpackage

// File: rtl/dd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// scratch left by one with the next binary MSB entering the units LSB.
module dd_step
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = DEF_NDIG
) (
  input  logic [DIG_W*NDIG-1:0] bcd_in,
  input  logic                  bin_msb,
  output logic [DIG_W*NDIG-1:0] bcd_out
);

  localparam int unsigned BCD_W = DIG_W * NDIG;

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (bcd_in[k*DIG_W +: DIG_W] >= DIG_W'(ADD3_TH)) begin
        adj[k*DIG_W +: DIG_W] = bcd_in[k*DIG_W +: DIG_W] + DIG_W'(3);
      end else begin
        adj[k*DIG_W +: DIG_W] = bcd_in[k*DIG_W +: DIG_W];
      end
    end
  end

  // Top bit of the adjusted scratch falls off; the digit count covers the input range.
  assign bcd_out = BCD_W'({adj, bin_msb});

endmodule

// File: rtl/bcd_sample_ctrl.sv
// Samples a binary count at a fixed rate (or on request) and converts it to
// BCD digits one bit per clock; digit outputs only change on completion.
module bcd_sample_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned NDIG       = DEF_NDIG,
  parameter int unsigned SAMPLE_DIV = 2_500_000
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             force_req,
  input  logic             hold,
  output logic [3:0]       BCD0,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD2,
  output logic [3:0]       BCD3,
  output logic [3:0]       BCD4,
  output logic             busy,
  output logic             valid,
  output logic             done
);

  localparam int unsigned BCD_W  = DIG_W * NDIG;
  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned ITER_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pend_q, pend_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [WIDTH-1:0]   shf_q, shf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic               tick;
  logic               req;
  logic [BCD_W-1:0]   step_out;

  dd_step #(.NDIG(NDIG)) u_step (
    .bcd_in  (scr_q),
    .bin_msb (shf_q[WIDTH-1]),
    .bcd_out (step_out)
  );

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign req  = pend_q | tick | force_req;

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    pend_d  = req;
    iter_d  = iter_q;
    scr_d   = scr_q;
    shf_d   = shf_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Requests that arrive while held stay pending until hold drops.
        if (req && !hold) begin
          state_d = SHIFT;
          shf_d   = value;
          scr_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      SHIFT: begin
        scr_d  = step_out;
        shf_d  = shf_q << 1;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(WIDTH - 1)) begin
          bcd_d   = step_out;
          valid_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      pend_q  <= 1'b0;
      iter_q  <= '0;
      scr_q   <= '0;
      shf_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      iter_q  <= iter_d;
      scr_q   <= scr_d;
      shf_q   <= shf_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign BCD0  = bcd_q[0*DIG_W +: DIG_W];
  assign BCD1  = bcd_q[1*DIG_W +: DIG_W];
  assign BCD2  = bcd_q[2*DIG_W +: DIG_W];
  assign BCD3  = bcd_q[3*DIG_W +: DIG_W];
  assign BCD4  = bcd_q[4*DIG_W +: DIG_W];
  assign busy  = busy_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule
